uart_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the CPU core. Receives a length-prefixed binary image over a UART RX line, assembles little-endian 32-bit words, writes them sequentially into instruction memory via a single-cycle write port, and asserts `uart_done` to release the CPU from its loading phase. Once `uart_done` is high, the loader ignores the line until reset.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/uart_rx.sv | 83 ++++++++
 rtl/uart_loader.sv | 152 +++++++++++++++
 tb/tb_uart_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader and its byte receiver.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERROR
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam int LOADER_LEN_BYTES = 2;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver with input synchronizer; byte_valid/frame_err pulse
// one cycle after the mid-stop-bit sample. No backpressure: each byte is a single pulse.
module uart_rx
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic          meta_q, sync_q, prev_q;
   rx_state_t     st_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          valid_q, ferr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         prev_q  <= 1'b1;
         st_q    <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         meta_q  <= rx;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         cnt_q   <= cnt_q + 1'b1;
         case (st_q)
            RX_IDLE: begin
               cnt_q <= '0;
               bit_q <= '0;
               if (prev_q && !sync_q) st_q <= RX_START;
            end
            RX_START: begin
               // A line that is high again at mid start bit was only a glitch.
               if (cnt_q == HALF_M1) begin
                  cnt_q <= '0;
                  st_q  <= sync_q ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q   <= '0;
                  shift_q <= {sync_q, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) st_q <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q <= '0;
                  if (sync_q) valid_q <= 1'b1;
                  else        ferr_q  <= 1'b1;
                  st_q <= RX_IDLE;
               end
            end
            default: st_q <= RX_IDLE;
         endcase
      end
   end

   assign byte_valid = valid_q;
   assign byte_data  = shift_q;
   assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// Length-prefixed UART image loader into instruction memory; we one cycle after the 4th byte.
// No backpressure. Optional trailing XOR checksum byte under UART_LOADER_CHECKSUM_EN.
module uart_loader
   import loader_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115_200,
   parameter int ADDR_W   = 14
) (
   input  logic              cpuclk,
   input  logic              rst,
   input  logic              rx,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              uart_done,
   output logic              err
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int LEN_W        = 8 * LOADER_LEN_BYTES;
   localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);

   logic        byte_valid, frame_err;
   logic [7:0]  byte_data;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (cpuclk),
      .rst        (rst),
      .rx         (rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   loader_state_t      st_q;
   logic [7:0]         len_lo_q;
   logic [LEN_W-1:0]   n_q;
   logic [ADDR_W-1:0]  ptr_q;
   logic [1:0]         idx_q;
   logic [23:0]        word_q;
   logic               we_q, done_q, err_q;
   logic [ADDR_W-1:0]  waddr_q;
   logic [31:0]        wdata_q;

   logic [LEN_W-1:0]   n_d;
   logic [LEN_W:0]     ptr_ext;
   logic               last_word;

   assign n_d       = {byte_data, len_lo_q};
   assign ptr_ext   = (LEN_W + 1)'(ptr_q);
   assign last_word = ((ptr_ext + 1'b1) == {1'b0, n_q});

`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0] csum_q;

   always_ff @(posedge cpuclk) begin
      if (rst)             csum_q <= '0;
      else if (byte_valid) csum_q <= csum_q ^ byte_data;
   end
`endif

   always_ff @(posedge cpuclk) begin
      if (rst) begin
         st_q     <= IDLE;
         len_lo_q <= '0;
         n_q      <= '0;
         ptr_q    <= '0;
         idx_q    <= '0;
         word_q   <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (st_q)
            IDLE: st_q <= LEN0;
            LEN0: begin
               if (byte_valid) begin
                  len_lo_q <= byte_data;
                  st_q     <= LEN1;
               end
            end
            LEN1: begin
               if (byte_valid) begin
                  n_q <= n_d;
                  if ({1'b0, n_d} > MAX_WORDS) begin
                     err_q <= 1'b1;
                     st_q  <= ERROR;
                  end else if (n_d == '0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                     st_q <= CSUM;
`else
                     done_q <= 1'b1;
                     st_q   <= DONE;
`endif
                  end else begin
                     st_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (byte_valid) begin
                  idx_q  <= idx_q + 1'b1;
                  word_q <= {byte_data, word_q[23:8]};
                  if (idx_q == 2'd3) begin
                     we_q    <= 1'b1;
                     waddr_q <= ptr_q;
                     wdata_q <= {byte_data, word_q};
                     ptr_q   <= ptr_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                     if (last_word) st_q <= CSUM;
`else
                     if (last_word) st_q <= DONE;
`endif
                  end
               end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            CSUM: begin
               if (byte_valid) begin
                  if (byte_data == csum_q) begin
                     done_q <= 1'b1;
                     st_q   <= DONE;
                  end else begin
                     err_q <= 1'b1;
                     st_q  <= ERROR;
                  end
               end
            end
`endif
            DONE:    done_q <= 1'b1;
            ERROR:   st_q   <= ERROR;
            default: st_q   <= ERROR;
         endcase
         // A framing error anywhere before completion is terminal.
         if (frame_err && (st_q != DONE) && (st_q != ERROR)) begin
            err_q <= 1'b1;
            st_q  <= ERROR;
         end
      end
   end

   assign we        = we_q;
   assign waddr     = waddr_q;
   assign wdata     = wdata_q;
   assign uart_done = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed scenarios plus random images against an image-level model.
module tb_uart_loader;

   localparam int ADDR_W = 4;
   localparam int CPB    = 16;
   localparam int CAP    = 16;

   typedef logic [7:0] bq_t [$];

   logic              cpuclk = 1'b0;
   logic              rst    = 1'b1;
   logic              rx     = 1'b1;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              uart_done;
   logic              err;

   uart_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_W(ADDR_W)) dut (
      .cpuclk    (cpuclk),
      .rst       (rst),
      .rx        (rx),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .uart_done (uart_done),
      .err       (err)
   );

   always #5 cpuclk = ~cpuclk;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   always @(posedge cpuclk) cyc <= cyc + 1;

   // write monitor
   logic [ADDR_W-1:0] wa [$];
   logic [31:0]       wd [$];
   int                wc [$];
   int                done_cyc = -1;
   int                err_cyc  = -1;
   int                we_long  = 0;
   logic              we_prev  = 1'b0;
   int                last_start = 0;

   always @(negedge cpuclk) begin
      if (we) begin
         wa.push_back(waddr);
         wd.push_back(wdata);
         wc.push_back(cyc);
      end
      if (we && we_prev) we_long++;
      we_prev = we;
      if (uart_done && done_cyc < 0) done_cyc = cyc;
      if (err && err_cyc < 0) err_cyc = cyc;
   end

   // reference model results
   logic [ADDR_W-1:0] exp_a [$];
   logic [31:0]       exp_d [$];
   logic              exp_done, exp_err;

   task automatic model(input bq_t b);
      int n;
      logic [7:0] x;
      exp_a.delete();
      exp_d.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (b.size() < 2) return;
      n = int'(b[0]) + 256 * int'(b[1]);
      if (n > CAP) begin
         exp_err = 1'b1;
         return;
      end
      x = b[0] ^ b[1];
      for (int i = 0; i < n; i++) begin
         int p = 2 + 4 * i;
         if (b.size() < p + 4) return;
         exp_a.push_back(ADDR_W'(i));
         exp_d.push_back({b[p+3], b[p+2], b[p+1], b[p]});
         x = x ^ b[p] ^ b[p+1] ^ b[p+2] ^ b[p+3];
      end
`ifdef UART_LOADER_CHECKSUM_EN
      if (b.size() < 2 + 4 * n + 1) return;
      if (b[2 + 4 * n] == x) exp_done = 1'b1;
      else                   exp_err  = 1'b1;
`else
      exp_done = 1'b1;
`endif
   endtask

   function automatic bq_t add_csum(input bq_t q);
      bq_t r = q;
`ifdef UART_LOADER_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      foreach (q[i]) x = x ^ q[i];
      r.push_back(x);
`endif
      return r;
   endfunction

   task automatic clr_mon();
      wa.delete();
      wd.delete();
      wc.delete();
      done_cyc = -1;
      err_cyc  = -1;
      we_long  = 0;
   endtask

   task automatic do_reset();
      @(negedge cpuclk);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge cpuclk);
      rst = 1'b0;
      clr_mon();
      repeat (2) @(negedge cpuclk);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      @(negedge cpuclk);
      rx = 1'b0;
      last_start = cyc;
      repeat (CPB) @(negedge cpuclk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge cpuclk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge cpuclk);
      rx = 1'b1;
   endtask

   task automatic send_image(input bq_t b);
      foreach (b[i]) send_byte(b[i], 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge cpuclk);
      checks++; if (we !== 1'b0) $display("FAIL reset_we got %b want 0", we); else passes++;
      checks++; if (waddr !== '0) $display("FAIL reset_waddr got %h want 0", waddr); else passes++;
      checks++; if (wdata !== '0) $display("FAIL reset_wdata got %h want 0", wdata); else passes++;
      checks++; if (uart_done !== 1'b0) $display("FAIL reset_done got %b want 0", uart_done); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passes++;
      rst = 1'b0;
      clr_mon();
      repeat (2) @(negedge cpuclk);
   endtask

   task automatic test_basic();
      bq_t img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      do_reset();
      send_image(add_csum(img));
      repeat (40) @(negedge cpuclk);
      checks++; if (wc.size() != 2) $display("FAIL basic_count got %0d want 2", wc.size()); else passes++;
      if (wc.size() == 2) begin
         checks++; if (wa[0] !== 4'd0 || wd[0] !== 32'h12345678)
            $display("FAIL basic_w0 got %h/%h want 0/12345678", wa[0], wd[0]); else passes++;
         checks++; if (wa[1] !== 4'd1 || wd[1] !== 32'hDEADBEEF)
            $display("FAIL basic_w1 got %h/%h want 1/deadbeef", wa[1], wd[1]); else passes++;
`ifndef UART_LOADER_CHECKSUM_EN
         checks++; if (done_cyc != wc[1] + 1)
            $display("FAIL basic_done_timing got %0d want %0d", done_cyc, wc[1] + 1); else passes++;
`endif
      end
      checks++; if (uart_done !== 1'b1 || err !== 1'b0)
         $display("FAIL basic_flags got done=%b err=%b want 1/0", uart_done, err); else passes++;
      checks++; if (we_long != 0) $display("FAIL basic_we_width got %0d long pulses want 0", we_long); else passes++;
   endtask

   task automatic test_zero_len();
      int t;
      do_reset();
      send_image(add_csum('{8'h00, 8'h00}));
      t = last_start;
      repeat (20) @(negedge cpuclk);
      checks++; if (done_cyc - t < 150 || done_cyc - t > 162)
         $display("FAIL zero_done_timing got %0d cycles after start want 150..162", done_cyc - t); else passes++;
      send_image('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
      repeat (20) @(negedge cpuclk);
      checks++; if (wc.size() != 0) $display("FAIL zero_no_we got %0d writes want 0", wc.size()); else passes++;
      checks++; if (uart_done !== 1'b1 || err !== 1'b0)
         $display("FAIL zero_flags got done=%b err=%b want 1/0", uart_done, err); else passes++;
   endtask

   task automatic test_oversize();
      int t;
      do_reset();
      send_image('{8'h11, 8'h00});
      t = last_start;
      send_image('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
      repeat (20) @(negedge cpuclk);
      checks++; if (err_cyc - t < 150 || err_cyc - t > 162)
         $display("FAIL oversize_err_timing got %0d want 150..162", err_cyc - t); else passes++;
      checks++; if (err !== 1'b1 || uart_done !== 1'b0 || wc.size() != 0)
         $display("FAIL oversize_state got err=%b done=%b writes=%0d want 1/0/0", err, uart_done, wc.size()); else passes++;
      do_reset();
      checks++; if (err !== 1'b0) $display("FAIL oversize_reset_clears got %b want 0", err); else passes++;
   endtask

   task automatic test_framing();
      do_reset();
      send_image('{8'h01, 8'h00});
      send_byte(8'h5A, 1'b0);
      send_image('{8'h01, 8'h02, 8'h03, 8'h04});
      repeat (20) @(negedge cpuclk);
      checks++; if (err !== 1'b1 || uart_done !== 1'b0 || wc.size() != 0)
         $display("FAIL framing_state got err=%b done=%b writes=%0d want 1/0/0", err, uart_done, wc.size()); else passes++;
   endtask

   task automatic test_glitch();
      do_reset();
      @(negedge cpuclk);
      rx = 1'b0;
      repeat (3) @(negedge cpuclk);
      rx = 1'b1;
      repeat (200) @(negedge cpuclk);
      checks++; if (wc.size() != 0 || err !== 1'b0 || uart_done !== 1'b0)
         $display("FAIL glitch_quiet got writes=%0d err=%b done=%b want 0/0/0", wc.size(), err, uart_done); else passes++;
      send_image(add_csum('{8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4}));
      repeat (20) @(negedge cpuclk);
      checks++; if (wc.size() != 1 || uart_done !== 1'b1)
         $display("FAIL glitch_then_load got writes=%0d done=%b want 1/1", wc.size(), uart_done); else passes++;
      if (wc.size() == 1) begin
         checks++; if (wd[0] !== 32'hD4C3B2A1) $display("FAIL glitch_data got %h want d4c3b2a1", wd[0]); else passes++;
      end
   endtask

   task automatic test_reset_midword();
      do_reset();
      send_image('{8'h01, 8'h00, 8'hAA, 8'hBB});
      @(negedge cpuclk);
      rx = 1'b0;
      repeat (40) @(negedge cpuclk);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge cpuclk);
      rst = 1'b0;
      clr_mon();
      repeat (5) @(negedge cpuclk);
      send_image(add_csum('{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11}));
      repeat (20) @(negedge cpuclk);
      checks++; if (wc.size() != 1) $display("FAIL midreset_count got %0d want 1", wc.size()); else passes++;
      if (wc.size() == 1) begin
         checks++; if (wa[0] !== 4'd0 || wd[0] !== 32'h11223344)
            $display("FAIL midreset_word got %h/%h want 0/11223344", wa[0], wd[0]); else passes++;
      end
      checks++; if (uart_done !== 1'b1 || err !== 1'b0)
         $display("FAIL midreset_flags got done=%b err=%b want 1/0", uart_done, err); else passes++;
   endtask

`ifdef UART_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int t;
      do_reset();
      send_image('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
      t = last_start;
      repeat (20) @(negedge cpuclk);
      checks++; if (uart_done !== 1'b1 || err !== 1'b0 || wc.size() != 1)
         $display("FAIL csum_good got done=%b err=%b writes=%0d want 1/0/1", uart_done, err, wc.size()); else passes++;
      checks++; if (done_cyc - t < 150 || done_cyc - t > 162)
         $display("FAIL csum_done_timing got %0d want 150..162", done_cyc - t); else passes++;
      do_reset();
      send_image('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06});
      repeat (20) @(negedge cpuclk);
      checks++; if (uart_done !== 1'b0 || err !== 1'b1)
         $display("FAIL csum_bad got done=%b err=%b want 0/1", uart_done, err); else passes++;
   endtask
`endif

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         bq_t img;
         int n;
         img.delete();
         n = (it == 3) ? int'($urandom_range(17, 20)) : int'($urandom_range(0, 6));
         img.push_back(8'(n));
         img.push_back(8'h00);
         if (n > CAP) begin
            img.push_back(8'($urandom));
            img.push_back(8'($urandom));
         end else begin
            for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
            img = add_csum(img);
`ifdef UART_LOADER_CHECKSUM_EN
            if (it == 1) img[img.size() - 1] = img[img.size() - 1] ^ 8'h40;
`endif
         end
         model(img);
         do_reset();
         send_image(img);
         repeat (30) @(negedge cpuclk);
         checks++; if (wc.size() != exp_a.size())
            $display("FAIL rand%0d_count got %0d want %0d", it, wc.size(), exp_a.size()); else passes++;
         for (int i = 0; i < wc.size() && i < exp_a.size(); i++) begin
            checks++; if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i])
               $display("FAIL rand%0d_w%0d got %h/%h want %h/%h", it, i, wa[i], wd[i], exp_a[i], exp_d[i]);
            else passes++;
         end
         checks++; if (uart_done !== exp_done || err !== exp_err)
            $display("FAIL rand%0d_flags got done=%b err=%b want %b/%b", it, uart_done, err, exp_done, exp_err); else passes++;
         checks++; if (we_long != 0) $display("FAIL rand%0d_we_width got %0d want 0", it, we_long); else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_oversize();
      test_framing();
      test_glitch();
      test_reset_midword();
`ifdef UART_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
